// File: rtl/tdm_demux1to2_pkg.sv
// Shared definitions for the TDM 1:2 receive demultiplexer.
// Channel indices, pointer-FSM encoding and default widths.
package tdm_demux1to2_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    // Encoding equals the channel pointer value, so sel is the state itself.
    typedef enum logic {
        EXP_CH0 = 1'b0,
        EXP_CH1 = 1'b1
    } state_t;

endpackage

// File: rtl/demux_out_reg.sv
// Per-channel valid/ready holding register with a delivered-word counter.
// A load in the same cycle as a drain wins, keeping one word per cycle throughput.
module demux_out_reg
    import tdm_demux1to2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
            cnt   <= cnt + CNT_W'(1);
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tdm_demux1to2.sv
// TDM 1:2 demultiplexer: routes an alternating ch0/ch1 word stream to two
// handshaked output registers, realigning on in_sync and flagging framing errors.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   EXP_CH0 | next unsynced word belongs to ch0 (sel=0)
//   EXP_CH1 | next unsynced word belongs to ch1 (sel=1)
module tdm_demux1to2
    import tdm_demux1to2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sync,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic             sel,
    output logic             frame_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    state_t state, state_next;
    logic   target;
    logic   tgt_valid;
    logic   tgt_ready;
    logic   accept;
    logic   load0;
    logic   load1;
    logic   err_set;

    assign sel    = (state == EXP_CH1);
    assign target = in_sync ? CH0 : sel;

    // Only the channel being written can stall the stream.
    assign tgt_valid = (target == CH1) ? out1_valid : out0_valid;
    assign tgt_ready = (target == CH1) ? out1_ready : out0_ready;
    assign in_ready  = !tgt_valid || tgt_ready;
    assign accept    = in_valid && in_ready;
    assign load0     = accept && (target == CH0);
    assign load1     = accept && (target == CH1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EXP_CH0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        if (accept) begin
            case (state)
                EXP_CH0: state_next = EXP_CH1;
                EXP_CH1: begin
                    if (in_sync) begin
                        state_next = EXP_CH1;
                        err_set    = 1'b1;
                    end else begin
                        state_next = EXP_CH0;
                    end
                end
                default: state_next = EXP_CH0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (err_set) begin
            frame_err <= 1'b1;
        end else if (err_clr) begin
            frame_err <= 1'b0;
        end
    end

    demux_out_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_out0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0),
        .load_data (in_data),
        .ready     (out0_ready),
        .data      (out0_data),
        .valid     (out0_valid),
        .cnt       (cnt0)
    );

    demux_out_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_out1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .load_data (in_data),
        .ready     (out1_ready),
        .data      (out1_data),
        .valid     (out1_valid),
        .cnt       (cnt1)
    );

endmodule
